// File: rtl/jtag_wb_master_arbiter.sv
// Round-robin arbiter that shares one Wishbone slave path between NUM_M
// JTAG-to-Wishbone bridge masters. A grant is held for the master's whole
// cyc period, so bursts stay atomic. A watchdog aborts a transfer that the
// slave never acknowledges, so a hung slave cannot lock out the JTAG host.
module jtag_wb_master_arbiter #(
   parameter int NUM_M   = 4,
   parameter int Dw      = 32,
   parameter int Aw      = 32,
   parameter int SELw    = 4,
   parameter int TAGw    = 3,
   parameter int TIMEOUT = 255,
   parameter int TOw     = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_M*SELw-1:0]  m_sel_i,
   input  logic [NUM_M*Dw-1:0]    m_dat_i,
   input  logic [NUM_M*Aw-1:0]    m_addr_i,
   input  logic [NUM_M*TAGw-1:0]  m_cti_i,
   input  logic [NUM_M-1:0]       m_stb_i,
   input  logic [NUM_M-1:0]       m_cyc_i,
   input  logic [NUM_M-1:0]       m_we_i,
   output logic [Dw-1:0]          m_dat_o,
   output logic [NUM_M-1:0]       m_ack_o,
   output logic [NUM_M-1:0]       m_err_o,
   output logic [SELw-1:0]        s_sel_o,
   output logic [Dw-1:0]          s_dat_o,
   output logic [Aw-1:0]          s_addr_o,
   output logic [TAGw-1:0]        s_cti_o,
   output logic                   s_stb_o,
   output logic                   s_cyc_o,
   output logic                   s_we_o,
   input  logic [Dw-1:0]          s_dat_i,
   input  logic                   s_ack_i,
   output logic [NUM_M-1:0]       grant_o,
   output logic                   timeout_o
);

   localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

   state_t           state_q, state_d;
   logic [NUM_M-1:0] grant_q, grant_d;
   logic [NUM_M-1:0] err_q, err_d;
   logic [IW-1:0]    last_q, last_d;
   logic [TOw-1:0]   wd_q, wd_d;
   logic             timeout_q, timeout_d;

   logic             in_grant;
   logic             g_cyc;
   logic             g_stb;
   logic             stall;
   logic             found;
   int               cand;

   // last_q doubles as the granted index while in GRANT or ABORT.
   assign in_grant = (state_q == GRANT);
   assign g_cyc    = m_cyc_i[last_q];
   assign g_stb    = m_stb_i[last_q] & g_cyc;
   assign stall    = in_grant & g_stb & ~s_ack_i;

   // Slave-side request path is a plain mux of the granted master's slices;
   // gating with reset drops the bus in the very cycle reset is sampled.
   assign s_sel_o  = m_sel_i[int'(last_q)*SELw +: SELw];
   assign s_dat_o  = m_dat_i[int'(last_q)*Dw +: Dw];
   assign s_addr_o = m_addr_i[int'(last_q)*Aw +: Aw];
   assign s_cti_o  = m_cti_i[int'(last_q)*TAGw +: TAGw];
   assign s_we_o   = m_we_i[last_q];
   assign s_cyc_o  = in_grant & g_cyc & ~reset;
   assign s_stb_o  = in_grant & g_stb & ~reset;

   assign m_dat_o   = s_dat_i;
   assign m_err_o   = err_q;
   assign grant_o   = grant_q;
   assign timeout_o = timeout_q;

   // Route the slave ack only to the granted master, and only in GRANT.
   always_comb begin
      m_ack_o = '0;
      if (in_grant) begin
         m_ack_o[last_q] = s_ack_i;
      end
   end

   // Next-state logic: round-robin pick in IDLE, hold/watchdog in GRANT, drain in ABORT.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      wd_d      = '0;
      timeout_d = 1'b0;
      err_d     = '0;
      found     = 1'b0;
      cand      = 0;
      case (state_q)
         IDLE: begin
            for (int i = 1; i <= NUM_M; i++) begin
               cand = (int'(last_q) + i) % NUM_M;
               if (!found && m_cyc_i[IW'(cand)]) begin
                  found               = 1'b1;
                  last_d              = IW'(cand);
                  grant_d             = '0;
                  grant_d[IW'(cand)]  = 1'b1;
                  state_d             = GRANT;
               end
            end
         end
         GRANT: begin
            if (!g_cyc) begin
               state_d = IDLE;
               grant_d = '0;
            end else if (stall) begin
               // An ack in the expiry cycle clears stall, so it wins over the abort.
               if (TIMEOUT != 0 && wd_q == TOw'(TIMEOUT)) begin
                  state_d       = ABORT;
                  err_d[last_q] = 1'b1;
                  timeout_d     = 1'b1;
               end else begin
                  wd_d = wd_q + TOw'(1);
               end
            end
         end
         ABORT: begin
            if (!g_cyc) begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State register; reset leaves master NUM_M-1 as last winner so master 0 goes first.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         last_q    <= IW'(NUM_M - 1);
         wd_q      <= '0;
         timeout_q <= 1'b0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
         err_q     <= err_d;
      end
   end

endmodule
